// File: rtl/alu_pkg.sv
// Shared opcode map and issuer FSM encoding for the ALU and its command issuer.
// OP_LAST bounds the valid opcode range; anything above it is rejected by the issuer.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_NOT  = 4'b0101;
    localparam logic [3:0] OP_EQ   = 4'b0110;
    localparam logic [3:0] OP_GT   = 4'b0111;
    localparam logic [3:0] OP_SHL  = 4'b1000;
    localparam logic [3:0] OP_SHR  = 4'b1001;
    localparam logic [3:0] OP_MUL  = 4'b1010;
    localparam logic [3:0] OP_LAST = OP_MUL;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } issuer_state_e;

    function automatic logic op_is_valid(input logic [3:0] op);
        return op <= OP_LAST;
    endfunction

endpackage

// File: rtl/alu_cmd_issuer.sv
// Issues commands to a combinational ALU from registers and returns tagged, registered responses.
// Valid op: response two edges after accept (one EXEC cycle); invalid op: response on the accept edge.
module alu_cmd_issuer
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAGW  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_opcode,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [1:0]       cmd_src,
    input  logic [TAGW-1:0]  cmd_tag,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_opcode,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    input  logic             alu_carry,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             rsp_carry,
    output logic             rsp_err,
    output logic [TAGW-1:0]  rsp_tag,
    output logic [WIDTH-1:0] acc,
    output logic [15:0]      op_count
);

    issuer_state_e    state_q, state_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [3:0]       alu_op_q, alu_op_d;
    logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic             rsp_zero_q, rsp_zero_d;
    logic             rsp_carry_q, rsp_carry_d;
    logic             rsp_err_q, rsp_err_d;
    logic [TAGW-1:0]  rsp_tag_q, rsp_tag_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [15:0]      op_count_q, op_count_d;
    logic             cmd_accept;

    assign cmd_ready  = (state_q == ST_IDLE) || ((state_q == ST_RESP) && rsp_ready);
    assign cmd_accept = cmd_valid && cmd_ready;

    always_comb begin
        state_d      = state_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_carry_d  = rsp_carry_q;
        rsp_err_d    = rsp_err_q;
        rsp_tag_d    = rsp_tag_q;
        acc_d        = acc_q;
        op_count_d   = op_count_q;

        case (state_q)
            ST_EXEC: begin
                rsp_result_d = alu_result;
                rsp_zero_d   = alu_zero;
                rsp_carry_d  = alu_carry;
                rsp_err_d    = 1'b0;
                acc_d        = alu_result;
                state_d      = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    op_count_d = op_count_q + 16'd1;
                    state_d    = ST_IDLE;
                end
            end
            default: ;
        endcase

        // Accept never coincides with EXEC, so this cannot clobber the capture above.
        // acc_q already holds the result of the response being retired.
        if (cmd_accept) begin
            rsp_tag_d = cmd_tag;
            if (op_is_valid(cmd_opcode)) begin
                alu_a_d  = cmd_src[0] ? acc_q : cmd_a;
                alu_b_d  = cmd_src[1] ? acc_q : cmd_b;
                alu_op_d = cmd_opcode;
                state_d  = ST_EXEC;
            end else begin
                rsp_result_d = '0;
                rsp_zero_d   = 1'b1;
                rsp_carry_d  = 1'b0;
                rsp_err_d    = 1'b1;
                state_d      = ST_RESP;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_carry_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_tag_q    <= '0;
            acc_q        <= '0;
            op_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_carry_q  <= rsp_carry_d;
            rsp_err_q    <= rsp_err_d;
            rsp_tag_q    <= rsp_tag_d;
            acc_q        <= acc_d;
            op_count_q   <= op_count_d;
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_opcode = alu_op_q;
    assign rsp_valid  = (state_q == ST_RESP);
    assign rsp_result = rsp_result_q;
    assign rsp_zero   = rsp_zero_q;
    assign rsp_carry  = rsp_carry_q;
    assign rsp_err    = rsp_err_q;
    assign rsp_tag    = rsp_tag_q;
    assign acc        = acc_q;
    assign op_count   = op_count_q;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Bench for alu_cmd_issuer: behavioural ALU, transaction-level response model, directed scenarios.
module tb_alu_cmd_issuer;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_opcode;
    logic [31:0] cmd_a, cmd_b;
    logic [1:0]  cmd_src;
    logic [3:0]  cmd_tag;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [3:0]  alu_opcode;
    logic        alu_zero, alu_carry;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_zero, rsp_carry, rsp_err;
    logic [3:0]  rsp_tag;
    logic [31:0] acc;
    logic [15:0] op_count;

    alu_cmd_issuer #(.WIDTH(32), .TAGW(4)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_src(cmd_src), .cmd_tag(cmd_tag),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_carry(alu_carry),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_zero(rsp_zero), .rsp_carry(rsp_carry), .rsp_err(rsp_err), .rsp_tag(rsp_tag),
        .acc(acc), .op_count(op_count)
    );

    always #5 clk = ~clk;

    // Reference ALU: returns {carry, zero, result}; SUB carry is the borrow.
    function automatic logic [33:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] w;
        logic [31:0] r;
        logic        c;
        w = '0; r = '0; c = 1'b0;
        case (op)
            OP_ADD: begin w = {1'b0, a} + {1'b0, b}; r = w[31:0]; c = w[32]; end
            OP_SUB: begin w = {1'b0, a} - {1'b0, b}; r = w[31:0]; c = w[32]; end
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_XOR: r = a ^ b;
            OP_NOT: r = ~a;
            OP_EQ:  r = {31'd0, a == b};
            OP_GT:  r = {31'd0, a > b};
            OP_SHL: r = a << b[4:0];
            OP_SHR: r = a >> b[4:0];
            OP_MUL: r = a * b;
            default: r = '0;
        endcase
        return {c, (r == 32'd0), r};
    endfunction

    always_comb {alu_carry, alu_zero, alu_result} = alu_f(alu_opcode, alu_a, alu_b);

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Transaction model: at most one outstanding response, each due a fixed number of edges after accept.
    typedef struct {
        logic [31:0] res;
        logic        z, c, e;
        logic [3:0]  tag;
        logic [31:0] acc_after;
        int          due;
    } exp_t;

    exp_t        q[$];
    exp_t        ne;
    logic [31:0] acc_m, a_m, b_m;
    logic [3:0]  op_m;
    logic [15:0] cnt_m;
    logic [33:0] fr;
    logic [31:0] ea, eb;
    logic        m_v, m_rdy;

    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            acc_m = '0; a_m = '0; b_m = '0; op_m = '0; cnt_m = '0;
        end else begin
            m_v   = (q.size() > 0) && (cyc >= q[0].due);
            m_rdy = (q.size() == 0) || (m_v && rsp_ready);
            chk("rsp_valid", rsp_valid, m_v);
            chk("cmd_ready", cmd_ready, m_rdy);
            if (m_v) begin
                chk("rsp_result", rsp_result, q[0].res);
                chk("rsp_zero", rsp_zero, q[0].z);
                chk("rsp_carry", rsp_carry, q[0].c);
                chk("rsp_err", rsp_err, q[0].e);
                chk("rsp_tag", rsp_tag, q[0].tag);
                chk("acc_resp", acc, q[0].acc_after);
            end else if (q.size() == 0) begin
                chk("acc_idle", acc, acc_m);
            end
            chk("op_count", op_count, cnt_m);
            chk("alu_a", alu_a, a_m);
            chk("alu_b", alu_b, b_m);
            chk("alu_opcode", alu_opcode, op_m);
            if (m_v && rsp_ready) begin
                void'(q.pop_front());
                cnt_m = cnt_m + 16'd1;
            end
            if (cmd_valid && m_rdy) begin
                ne.tag = cmd_tag;
                if (cmd_opcode <= 4'd10) begin
                    ea = cmd_src[0] ? acc_m : cmd_a;
                    eb = cmd_src[1] ? acc_m : cmd_b;
                    fr = alu_f(cmd_opcode, ea, eb);
                    a_m = ea; b_m = eb; op_m = cmd_opcode;
                    ne.res = fr[31:0]; ne.z = fr[32]; ne.c = fr[33]; ne.e = 1'b0;
                    acc_m = fr[31:0];
                    ne.due = cyc + 2;
                end else begin
                    ne.res = '0; ne.z = 1'b1; ne.c = 1'b0; ne.e = 1'b1;
                    ne.due = cyc + 1;
                end
                ne.acc_after = acc_m;
                q.push_back(ne);
            end
        end
    end

    logic [31:0] hs_res [8];
    int          hs_n = 0;
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready && hs_n < 8) begin
            hs_res[hs_n] = rsp_result;
            hs_n++;
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] src, input logic [3:0] tag);
        logic ok;
        ok = 1'b0;
        cmd_opcode = op; cmd_a = a; cmd_b = b; cmd_src = src; cmd_tag = tag;
        cmd_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (cmd_ready) begin ok = 1'b1; break; end
        end
        chk("send_accepted", ok, 1'b1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    int          acc_c [4];
    logic [3:0]  inv_ops [3];
    logic [31:0] and_a [4];
    logic [31:0] and_b [4];

    initial begin
        rst = 1'b1; rsp_ready = 1'b0; cmd_valid = 1'b0;
        cmd_opcode = '0; cmd_a = '0; cmd_b = '0; cmd_src = '0; cmd_tag = '0;
        inv_ops[0] = 4'hB; inv_ops[1] = 4'hF; inv_ops[2] = 4'hD;
        and_a[0] = 32'hF0; and_b[0] = 32'h3C;
        and_a[1] = 32'hFF; and_b[1] = 32'h0F;
        and_a[2] = 32'hAA; and_b[2] = 32'h55;
        and_a[3] = 32'h12345678; and_b[3] = 32'hFFFF0000;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_acc", acc, 32'd0);
        chk("rst_op_count", op_count, 16'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_rsp_result", rsp_result, 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Add 5+3, response held to observe latency
        send(OP_ADD, 32'd5, 32'd3, 2'b00, 4'd7);
        @(negedge clk);
        chk("add_exec_not_valid", rsp_valid, 1'b0);
        @(negedge clk);
        chk("add_valid", rsp_valid, 1'b1);
        chk("add_result", rsp_result, 32'd8);
        chk("add_zero", rsp_zero, 1'b0);
        chk("add_tag", rsp_tag, 4'd7);
        chk("add_acc", acc, 32'd8);

        // Chained subtract accepted on the add's handshake
        @(posedge clk); #1 rsp_ready = 1'b1;
        send(OP_SUB, 32'h123, 32'd8, 2'b01, 4'd2);
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("sub_alu_a_from_acc", alu_a, 32'd8);
        @(negedge clk);
        chk("sub_result", rsp_result, 32'd0);
        chk("sub_zero", rsp_zero, 1'b1);
        chk("sub_acc", acc, 32'd0);

        // Backpressure with a second command waiting
        @(posedge clk); #1 rsp_ready = 1'b1;
        send(OP_OR, 32'hA0, 32'h0B, 2'b00, 4'd3);
        rsp_ready = 1'b0;
        cmd_opcode = OP_XOR; cmd_a = 32'd0; cmd_b = 32'hFF; cmd_src = 2'b01; cmd_tag = 4'd4;
        cmd_valid = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_cmd_ready", cmd_ready, 1'b0);
            chk("stall_rsp_valid", rsp_valid, 1'b1);
            chk("stall_result", rsp_result, 32'hAB);
        end
        chk("stall_op_count", op_count, 16'd2);
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(posedge clk); #1 cmd_valid = 1'b0; rsp_ready = 1'b0;
        @(negedge clk);
        chk("bp_op_count_inc", op_count, 16'd3);
        chk("bp_alu_a", alu_a, 32'hAB);
        @(negedge clk);
        chk("xor_result", rsp_result, 32'h54);
        chk("xor_acc", acc, 32'h54);

        // Invalid opcode leaves ALU ports and accumulator alone
        @(posedge clk); #1 rsp_ready = 1'b1;
        send(4'hC, 32'h1, 32'h2, 2'b00, 4'd9);
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("inv_valid", rsp_valid, 1'b1);
        chk("inv_err", rsp_err, 1'b1);
        chk("inv_result", rsp_result, 32'd0);
        chk("inv_zero", rsp_zero, 1'b1);
        chk("inv_tag", rsp_tag, 4'd9);
        chk("inv_alu_a", alu_a, 32'hAB);
        chk("inv_alu_b", alu_b, 32'hFF);
        chk("inv_alu_op", alu_opcode, OP_XOR);
        chk("inv_acc", acc, 32'h54);

        // Invalid ops sustain one per cycle
        @(posedge clk); #1 rsp_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cmd_opcode = inv_ops[k]; cmd_tag = 4'(k); cmd_valid = 1'b1;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (cmd_ready) break;
            end
            acc_c[k] = cyc;
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        chk("inv_spacing_1", acc_c[1] - acc_c[0], 1);
        chk("inv_spacing_2", acc_c[2] - acc_c[1], 1);
        repeat (2) @(posedge clk); #1;

        // Reset during EXEC discards the pending response
        send(OP_ADD, 32'd1, 32'd1, 2'b00, 4'd5);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_exec_rsp_valid", rsp_valid, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rel_cmd_ready", cmd_ready, 1'b1);
        chk("rel_acc", acc, 32'd0);
        chk("rel_op_count", op_count, 16'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rel_no_rsp", rsp_valid, 1'b0);
        end

        // Back-to-back ANDs at one per two cycles
        @(posedge clk); #1;
        hs_n = 0;
        for (int k = 0; k < 4; k++) begin
            cmd_opcode = OP_AND; cmd_a = and_a[k]; cmd_b = and_b[k]; cmd_src = 2'b00;
            cmd_tag = 4'(k + 1); cmd_valid = 1'b1;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (cmd_ready) break;
            end
            acc_c[k] = cyc;
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        for (int i = 0; i < 10 && hs_n < 4; i++) @(negedge clk);
        chk("tp_rsp_count", hs_n, 4);
        for (int k = 1; k < 4; k++) chk("tp_spacing", acc_c[k] - acc_c[k-1], 2);
        chk("tp_res0", hs_res[0], 32'h30);
        chk("tp_res1", hs_res[1], 32'h0F);
        chk("tp_res2", hs_res[2], 32'h00);
        chk("tp_res3", hs_res[3], 32'h12340000);
        @(negedge clk);
        chk("tp_op_count", op_count, 16'd4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1);
    end

endmodule
